// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the core run/stop sequencer: command opcodes, halt causes, FSM states.
package run_ctrl_pkg;

  localparam int PC_W      = 32;
  localparam int INSTRET_W = 64;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RUN     = 3'd1,
    OP_STEP    = 3'd2,
    OP_RUN_CYC = 3'd3,
    OP_HALT    = 3'd4,
    OP_SET_BP  = 3'd5,
    OP_CLR_BP  = 3'd6,
    OP_NOP7    = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_CMD        = 3'd1,
    CAUSE_STEP_DONE  = 3'd2,
    CAUSE_CYC_DONE   = 3'd3,
    CAUSE_BREAKPOINT = 3'd4,
    CAUSE_ECALL      = 3'd5
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_RUN_CYC = 2'd3
  } run_state_e;

  // Ops that start execution; these stall unless the core is halted.
  function automatic logic op_is_run(input cmd_op_e op);
    return (op == OP_RUN) || (op == OP_STEP) || (op == OP_RUN_CYC);
  endfunction

endpackage

// File: rtl/run_ctrl_cnt.sv
// Loadable down-counter shared by the STEP and RUN_CYC modes; never wraps below zero.
module run_ctrl_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  assign zero_o = (cnt_o == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_o <= cnt_o - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/stop sequencer driving the core pause input (free run, step N, run N cycles, BP/ecall halt).
// Optional retired-instruction counter enabled by defining CPU_RUN_CTRL_PERF_EN.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit BOOT_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_arg_i,
  input  logic             retire_i,
  input  logic [31:0]      retire_pc_i,
  input  logic             ecall_i,
  output logic             pause_o,
  output logic             halted_o,
  output logic [2:0]       halt_cause_o,
  output logic             halt_pulse_o,
  output logic [63:0]      instret_o
);

  run_state_e      state;
  halt_cause_e     cause_q;
  cmd_op_e         op;
  logic            bp_valid;
  logic [PC_W-1:0] bp_pc;
  logic            resume_exempt;
  logic            cmd_fire;
  logic            acc_retire;
  logic            running;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_zero;
  logic             cnt_last;

  logic        hit_ecall;
  logic        hit_bp;
  logic        hit_step;
  logic        hit_cyc;
  logic        hit_cmd;
  logic        stop_req;
  halt_cause_e stop_cause;

  assign op           = cmd_op_e'(cmd_op_i);
  assign running      = (state != ST_HALT);
  assign halted_o     = (state == ST_HALT);
  assign halt_cause_o = cause_q;
  assign cmd_ready_o  = !running || !op_is_run(op);
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign acc_retire   = retire_i && !pause_o;
  assign cnt_last     = (cnt_q == CNT_W'(1));

  assign cnt_load     = !running && cmd_fire && ((op == OP_STEP) || (op == OP_RUN_CYC));
  assign cnt_load_val = ((op == OP_STEP) && (cmd_arg_i == '0)) ? CNT_W'(1) : cmd_arg_i;
  assign cnt_dec      = !cnt_zero &&
                        (((state == ST_STEP) && acc_retire) || (state == ST_RUN_CYC));

  run_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_q),
    .zero_o     (cnt_zero)
  );

  // Stop sources in a running state; several may coincide, the highest-priority one names the cause.
  always_comb begin
    hit_ecall  = running && acc_retire && ecall_i;
    hit_bp     = running && acc_retire && bp_valid && !resume_exempt && (retire_pc_i == bp_pc);
    hit_step   = (state == ST_STEP) && acc_retire && cnt_last;
    hit_cyc    = (state == ST_RUN_CYC) && cnt_last;
    hit_cmd    = running && cmd_fire && (op == OP_HALT);
    stop_cause = CAUSE_NONE;
    if (hit_ecall) begin
      stop_cause = CAUSE_ECALL;
    end else if (hit_bp) begin
      stop_cause = CAUSE_BREAKPOINT;
    end else if (hit_step) begin
      stop_cause = CAUSE_STEP_DONE;
    end else if (hit_cyc) begin
      stop_cause = CAUSE_CYC_DONE;
    end else if (hit_cmd) begin
      stop_cause = CAUSE_CMD;
    end
    stop_req = (stop_cause != CAUSE_NONE);
  end

  // pause_o tracks the next state so the pipeline freezes the cycle after a halt is decided.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT_RUN ? ST_RUN : ST_HALT;
      pause_o       <= !BOOT_RUN;
      cause_q       <= CAUSE_NONE;
      halt_pulse_o  <= 1'b0;
      bp_valid      <= 1'b0;
      bp_pc         <= '0;
      resume_exempt <= 1'b0;
    end else begin
      halt_pulse_o <= 1'b0;

      if (cmd_fire && (op == OP_SET_BP)) begin
        bp_valid <= 1'b1;
        bp_pc    <= PC_W'(cmd_arg_i);
      end else if (cmd_fire && (op == OP_CLR_BP)) begin
        bp_valid <= 1'b0;
      end

      if (acc_retire) begin
        resume_exempt <= 1'b0;
      end

      unique case (state)
        ST_HALT: begin
          if (cmd_fire) begin
            case (op)
              OP_RUN: begin
                state         <= ST_RUN;
                pause_o       <= 1'b0;
                cause_q       <= CAUSE_NONE;
                resume_exempt <= 1'b1;
              end
              OP_STEP: begin
                state         <= ST_STEP;
                pause_o       <= 1'b0;
                cause_q       <= CAUSE_NONE;
                resume_exempt <= 1'b1;
              end
              OP_RUN_CYC: begin
                if (cmd_arg_i == '0) begin
                  halt_pulse_o <= 1'b1;
                  cause_q      <= CAUSE_CYC_DONE;
                end else begin
                  state         <= ST_RUN_CYC;
                  pause_o       <= 1'b0;
                  cause_q       <= CAUSE_NONE;
                  resume_exempt <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (stop_req) begin
            state        <= ST_HALT;
            pause_o      <= 1'b1;
            halt_pulse_o <= 1'b1;
            cause_q      <= stop_cause;
          end
        end
      endcase
    end
  end

`ifdef CPU_RUN_CTRL_PERF_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (acc_retire) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule
